pipeline_hazard_ctrl: RTL and testbench

Central hazard sequencer for the 5-stage LEGv8 pipeline. It decodes the instruction held in IF/ID using the same format classes as immediate extension (B, CBZ, I, D, R). It detects load-use hazards against ID/EX, holds the required bubbles, and sequences multi-cycle flushes after a taken branch resolves in MEM. It drives the PC and pipeline-register write/flush enables and keeps saturating performance counters.

---
 rtl/legv8_pkg.sv | 48 ++++
 rtl/instr_src_decode.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode constants: opcode fields, XZR, instruction format classes.
// Also hosts the hazard sequencer state encoding.
package legv8_pkg;

    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam logic [4:0]  XZR = 5'd31;

    typedef enum logic [2:0] {
        FMT_B,
        FMT_CBZ,
        FMT_I,
        FMT_D,
        FMT_R
    } fmt_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LU_STALL,
        ST_BR_FLUSH
    } hz_state_e;

    // Same classification order as immediate extension; anything unmatched is R.
    function automatic fmt_e decode_fmt(input logic [31:0] instr);
        fmt_e f;
        if (instr[31:26] == OP_B) begin
            f = FMT_B;
        end else if (instr[31:24] == OP_CBZ) begin
            f = FMT_CBZ;
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_ANDI ||
                     instr[31:22] == OP_ORRI || instr[31:22] == OP_SUBI) begin
            f = FMT_I;
        end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            f = FMT_D;
        end else begin
            f = FMT_R;
        end
        return f;
    endfunction

endpackage

// File: rtl/instr_src_decode.sv
// Extracts which source register fields an IF/ID instruction actually reads.
module instr_src_decode
    import legv8_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        uses_rn_o,
    output logic        uses_rm_o,
    output logic        uses_rt_o,
    output logic [4:0]  rn_o,
    output logic [4:0]  rm_o,
    output logic [4:0]  rt_o
);

    fmt_e fmt;
    logic unused_imm_bits;

    assign fmt = decode_fmt(instr_i);

    assign rn_o = instr_i[9:5];
    assign rm_o = instr_i[20:16];
    assign rt_o = instr_i[4:0];

    // Only STUR reads Rt among the D-format loads/stores; LDUR writes it.
    assign uses_rn_o = (fmt == FMT_I) || (fmt == FMT_D) || (fmt == FMT_R);
    assign uses_rm_o = (fmt == FMT_R);
    assign uses_rt_o = (fmt == FMT_CBZ) ||
                       ((fmt == FMT_D) && (instr_i[31:21] == OP_STUR));

    assign unused_imm_bits = ^instr_i[15:10];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall and taken-branch flush sequencer for the 5-stage LEGv8 pipeline.
//
// state       | meaning
// ST_RUN      | normal flow; hazard and branch detection active
// ST_LU_STALL | extra load-use bubble cycles, cnt counts remaining minus one
// ST_BR_FLUSH | extra IF/ID flush cycles after a taken branch, cnt as above
module pipeline_hazard_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned LU_BUBBLES   = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_valid,
    input  logic             mem_branch_taken,
    input  logic             dmem_stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] FLUSH_PRELOAD =
        (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_e        state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_inc, flush_inc;

    logic             uses_rn, uses_rm, uses_rt;
    logic [4:0]       rn, rm, rt;
    logic             src_match, hz;

    instr_src_decode u_src_decode (
        .instr_i   (id_instr),
        .uses_rn_o (uses_rn),
        .uses_rm_o (uses_rm),
        .uses_rt_o (uses_rt),
        .rn_o      (rn),
        .rm_o      (rm),
        .rt_o      (rt)
    );

    assign src_match = (uses_rn && (rn == ex_rd)) ||
                       (uses_rm && (rm == ex_rd)) ||
                       (uses_rt && (rt == ex_rd));

    assign hz = id_valid && ex_valid && ex_mem_read && (ex_rd != XZR) && src_match;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (dmem_stall) begin
            // Whole pipeline frozen: everything holds, including cnt.
        end else if (mem_branch_taken) begin
            pc_write    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_BR_FLUSH;
                cnt_d   = FLUSH_PRELOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        end else begin
            unique case (state_q)
                ST_BR_FLUSH: begin
                    pc_write   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (cnt_q == 2'd0) state_d = ST_RUN;
                    else               cnt_d   = cnt_q - 2'd1;
                end
                ST_LU_STALL: begin
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                    if (cnt_q == 2'd0) state_d = ST_RUN;
                    else               cnt_d   = cnt_q - 2'd1;
                end
                default: begin
                    if (hz) begin
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                        if (LU_BUBBLES == 2) begin
                            state_d = ST_LU_STALL;
                            cnt_d   = 2'd0;
                        end
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
            endcase
        end
    end

    assign stall_cnt_d = (stall_inc && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    assign flush_cnt_d = (flush_inc && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign busy      = (state_q != ST_RUN);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three configurations driven in parallel.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] id_instr;
    logic        id_valid, ex_mem_read, ex_valid, mem_branch_taken, dmem_stall;
    logic [4:0]  ex_rd;

    logic a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush, a_exmem_flush, a_busy;
    logic b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_exmem_flush, b_busy;
    logic c_pc_write, c_ifid_write, c_ifid_flush, c_idex_flush, c_exmem_flush, c_busy;
    logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
    logic [1:0]  c_stall_cnt, c_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] I_ADD  = {11'b10001011000, 5'd4, 6'd0, 5'd2, 5'd3};
    localparam logic [31:0] I_ADDZ = {11'b10001011000, 5'd4, 6'd0, 5'd31, 5'd3};
    localparam logic [31:0] I_B    = {6'b000101, 26'd5};
    localparam logic [31:0] I_CBZ  = {8'b10110100, 19'd0, 5'd7};
    localparam logic [31:0] I_ADDI = {10'b1001000100, 12'd0, 5'd6, 5'd1};
    localparam logic [31:0] I_STUR = {11'b11111000000, 9'd0, 2'b00, 5'd1, 5'd9};
    localparam logic [31:0] I_LDUR = {11'b11111000010, 9'd0, 2'b00, 5'd1, 5'd9};

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        idv;
        logic        ev;
        logic        mr;
        logic        stall;
    } vec_t;

    pipeline_hazard_ctrl #(.LU_BUBBLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) ua (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .mem_branch_taken(mem_branch_taken), .dmem_stall(dmem_stall),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .idex_flush(a_idex_flush), .exmem_flush(a_exmem_flush), .busy(a_busy),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_hazard_ctrl #(.LU_BUBBLES(2), .FLUSH_CYCLES(3), .CNT_W(16)) ub (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .mem_branch_taken(mem_branch_taken), .dmem_stall(dmem_stall),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .exmem_flush(b_exmem_flush), .busy(b_busy),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    pipeline_hazard_ctrl #(.LU_BUBBLES(1), .FLUSH_CYCLES(1), .CNT_W(2)) uc (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .mem_branch_taken(mem_branch_taken), .dmem_stall(dmem_stall),
        .pc_write(c_pc_write), .ifid_write(c_ifid_write), .ifid_flush(c_ifid_flush),
        .idex_flush(c_idex_flush), .exmem_flush(c_exmem_flush), .busy(c_busy),
        .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_instr = 32'd0; id_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        ex_valid = 1'b0; mem_branch_taken = 1'b0; dmem_stall = 1'b0;
    endtask

    task automatic set_hz();
        id_instr = I_ADD; id_valid = 1'b1; ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd2;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++; if (a_pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write: got %0b want 1", a_pc_write); end
        n_tests++; if (a_ifid_write !== 1'b1) begin n_fail++; $display("FAIL reset_ifid_write: got %0b want 1", a_ifid_write); end
        n_tests++; if ({a_ifid_flush, a_idex_flush, a_exmem_flush} !== 3'b000) begin n_fail++; $display("FAIL reset_flushes: got %03b want 000", {a_ifid_flush, a_idex_flush, a_exmem_flush}); end
        n_tests++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b/%0b want 0/0", a_busy, b_busy); end
        n_tests++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", a_stall_cnt, a_flush_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_hz();
        #1;
        n_tests++; if ({a_pc_write, a_ifid_write, a_idex_flush} !== 3'b001) begin n_fail++; $display("FAIL lu_stall_outputs: got %03b want 001", {a_pc_write, a_ifid_write, a_idex_flush}); end
        cyc();
        ex_valid = 1'b0;
        #1;
        n_tests++; if (a_pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %0b want 1", a_pc_write); end
        n_tests++; if (a_stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", a_stall_cnt); end
    endtask

    task automatic test_decode_table();
        vec_t vecs [0:13];
        vecs[0]  = '{I_ADD,  5'd2,  1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{I_ADD,  5'd4,  1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{I_ADD,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{I_ADDZ, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{I_B,    5'd5,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{I_CBZ,  5'd7,  1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{I_CBZ,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{I_ADDI, 5'd6,  1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{I_ADDI, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{I_STUR, 5'd9,  1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{I_LDUR, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{I_ADD,  5'd2,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{I_ADD,  5'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{I_ADD,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i <= 13; i++) begin
            id_instr = vecs[i].instr; ex_rd = vecs[i].rd; id_valid = vecs[i].idv;
            ex_valid = vecs[i].ev; ex_mem_read = vecs[i].mr;
            #1;
            n_tests++;
            if ({a_pc_write, a_ifid_write, a_idex_flush} !== {!vecs[i].stall, !vecs[i].stall, vecs[i].stall}) begin
                n_fail++;
                $display("FAIL decode_vec%0d: got pc/ifid/idex=%03b want stall=%0b", i, {a_pc_write, a_ifid_write, a_idex_flush}, vecs[i].stall);
            end
            cyc();
        end
    endtask

    task automatic test_two_bubbles();
        do_reset();
        set_hz();
        #1;
        n_tests++; if (b_pc_write !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL lu2_first: got pc=%0b busy=%0b want 0/0", b_pc_write, b_busy); end
        cyc();
        ex_valid = 1'b0;
        #1;
        n_tests++; if ({b_pc_write, b_ifid_write, b_idex_flush} !== 3'b001) begin n_fail++; $display("FAIL lu2_second: got %03b want 001", {b_pc_write, b_ifid_write, b_idex_flush}); end
        n_tests++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL lu2_busy: got %0b want 1", b_busy); end
        cyc();
        #1;
        n_tests++; if (b_pc_write !== 1'b1 || b_busy !== 1'b0) begin n_fail++; $display("FAIL lu2_release: got pc=%0b busy=%0b want 1/0", b_pc_write, b_busy); end
        n_tests++; if (b_stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lu2_stall_cnt: got %0d want 2", b_stall_cnt); end
    endtask

    task automatic test_multi_flush();
        int nif_b, nex_b, nif_a;
        do_reset();
        mem_branch_taken = 1'b1;
        #1;
        n_tests++; if ({b_pc_write, b_ifid_flush, b_idex_flush, b_exmem_flush} !== 4'b1111) begin n_fail++; $display("FAIL br_first: got %04b want 1111", {b_pc_write, b_ifid_flush, b_idex_flush, b_exmem_flush}); end
        nif_b = 1; nex_b = 1; nif_a = 1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            mem_branch_taken = 1'b0;
            #1;
            nif_b += int'(b_ifid_flush);
            nex_b += int'(b_exmem_flush);
            nif_a += int'(a_ifid_flush);
        end
        n_tests++; if (nif_b != 3) begin n_fail++; $display("FAIL br3_ifid_cycles: got %0d want 3", nif_b); end
        n_tests++; if (nex_b != 1) begin n_fail++; $display("FAIL br3_exmem_cycles: got %0d want 1", nex_b); end
        n_tests++; if (nif_a != 1) begin n_fail++; $display("FAIL br1_ifid_cycles: got %0d want 1", nif_a); end
        n_tests++; if (b_flush_cnt !== 16'd1 || b_busy !== 1'b0) begin n_fail++; $display("FAIL br3_end: got cnt=%0d busy=%0b want 1/0", b_flush_cnt, b_busy); end
    endtask

    task automatic test_simultaneous();
        int nif, last;
        do_reset();
        set_hz();
        mem_branch_taken = 1'b1;
        #1;
        n_tests++; if ({a_pc_write, a_idex_flush, a_exmem_flush} !== 3'b111) begin n_fail++; $display("FAIL sim_branch_wins: got %03b want 111", {a_pc_write, a_idex_flush, a_exmem_flush}); end
        cyc();
        clr();
        #1;
        n_tests++; if (a_stall_cnt !== 16'd0 || b_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL sim_stall_cnt: got %0d/%0d want 0/0", a_stall_cnt, b_stall_cnt); end
        n_tests++; if (a_flush_cnt !== 16'd1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL sim_flush: got cnt=%0d busy=%0b want 1/1", a_flush_cnt, b_busy); end

        do_reset();
        mem_branch_taken = 1'b1;
        nif = 1; last = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            mem_branch_taken = 1'b0;
            dmem_stall = (k == 2 || k == 3);
            if (k == 2 || k == 3) set_hz(); else begin id_valid = 1'b0; ex_valid = 1'b0; end
            #1;
            if (k == 2) begin
                n_tests++; if ({b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_exmem_flush} !== 5'b00000) begin n_fail++; $display("FAIL dmem_outputs: got %05b want 00000", {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_exmem_flush}); end
            end
            if (k == 3) begin
                n_tests++; if (b_flush_cnt !== 16'd1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL dmem_hold: got cnt=%0d busy=%0b want 1/1", b_flush_cnt, b_busy); end
            end
            if (b_ifid_flush) begin nif++; last = k; end
        end
        n_tests++; if (nif != 3 || last != 4) begin n_fail++; $display("FAIL dmem_flush_len: got %0d cycles ending %0d want 3 ending 4", nif, last); end
        n_tests++; if (a_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL dmem_stall_frozen: got %0d want 0", a_stall_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_branch_taken = 1'b1;
        cyc();
        mem_branch_taken = 1'b0;
        #1;
        n_tests++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy: got %0b want 1", b_busy); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        n_tests++; if (b_busy !== 1'b0 || b_flush_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_state: got busy=%0b cnt=%0d want 0/0", b_busy, b_flush_cnt); end
        n_tests++; if (b_ifid_flush !== 1'b0 || b_pc_write !== 1'b1) begin n_fail++; $display("FAIL rstmid_outputs: got flush=%0b pc=%0b want 0/1", b_ifid_flush, b_pc_write); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_hz();
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k == 3) begin
                n_tests++; if (c_stall_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_stall_reach: got %0d want 3", c_stall_cnt); end
            end
        end
        n_tests++; if (c_stall_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_stall_hold: got %0d want 3", c_stall_cnt); end
        n_tests++; if (a_stall_cnt !== 16'd5) begin n_fail++; $display("FAIL wide_stall_cnt: got %0d want 5", a_stall_cnt); end
        clr();
        mem_branch_taken = 1'b1;
        for (int k = 1; k <= 5; k++) cyc();
        mem_branch_taken = 1'b0;
        n_tests++; if (c_flush_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_flush_hold: got %0d want 3", c_flush_cnt); end
    endtask

    initial begin
        clr();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_decode_table();
        test_two_bubbles();
        test_multi_flush();
        test_simultaneous();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
